// File: rtl/motors_pwm_multi.sv
// Multi-channel edge-aligned PWM generator with a shared counter, double-buffered duty and
// period values, and an optional per-period duty slew limit.
module motors_pwm_multi #(
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned PRESCALE  = 1,
    parameter int unsigned RAMP_STEP = 0,
    localparam int unsigned ChW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [WIDTH-1:0]    period,
    input  logic                wr_en,
    input  logic [ChW-1:0]      wr_ch,
    input  logic [WIDTH-1:0]    wr_duty,
    output logic [CHANNELS-1:0] PWM_output,
    output logic                period_tick,
    output logic                ramping
);

    localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PsW-1:0]      ps_q, ps_d;
    logic [WIDTH-1:0]    count_q, count_d;
    logic [WIDTH-1:0]    shadow_q, shadow_d;
    logic [WIDTH-1:0]    target_q [CHANNELS];
    logic [WIDTH-1:0]    target_d [CHANNELS];
    logic [WIDTH-1:0]    active_q [CHANNELS];
    logic [WIDTH-1:0]    active_d [CHANNELS];
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                tick_q, tick_d;
    logic                ramp_q, ramp_d;
    logic                run_q, run_d;

    logic                start;
    logic                step;
    logic                wrap;
    logic [WIDTH-1:0]    eff_period;

    // Move cur toward tgt by at most RAMP_STEP, never overshooting.
    function automatic logic [WIDTH-1:0] slew(input logic [WIDTH-1:0] cur,
                                             input logic [WIDTH-1:0] tgt);
        logic [WIDTH-1:0] diff;
        slew = tgt;
        if (RAMP_STEP != 0) begin
            if (tgt > cur) begin
                diff = tgt - cur;
                if (32'(diff) > RAMP_STEP) slew = cur + WIDTH'(RAMP_STEP);
            end else begin
                diff = cur - tgt;
                if (32'(diff) > RAMP_STEP) slew = cur - WIDTH'(RAMP_STEP);
            end
        end
    endfunction

    // Counter, prescaler and period shadow.
    always_comb begin
        run_d      = en;
        start      = en & ~run_q;
        // The first enabled cycle compares against the freshly loaded period.
        eff_period = start ? period : shadow_q;
        step       = en && (ps_q == PsW'(PRESCALE - 1));
        wrap       = step && (count_q == eff_period);
        ps_d       = ps_q;
        count_d    = count_q;
        shadow_d   = shadow_q;
        tick_d     = wrap;
        if (!en) begin
            ps_d    = '0;
            count_d = '0;
        end else begin
            ps_d = step ? '0 : ps_q + 1'b1;
            if (step) count_d = wrap ? '0 : count_q + 1'b1;
            if (start || wrap) shadow_d = period;
        end
    end

    // Per-channel duty buffers and outputs; a wrap consumes the pre-write target.
    always_comb begin
        pwm_d  = '0;
        ramp_d = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            pwm_d[i]    = en && (count_q < active_q[i]);
            active_d[i] = wrap ? slew(active_q[i], target_q[i]) : active_q[i];
            target_d[i] = target_q[i];
            if (wr_en && (32'(wr_ch) == i)) target_d[i] = wr_duty;
            if (active_d[i] != target_d[i]) ramp_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ps_q     <= '0;
            count_q  <= '0;
            shadow_q <= '0;
            pwm_q    <= '0;
            tick_q   <= 1'b0;
            ramp_q   <= 1'b0;
            run_q    <= 1'b0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                target_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            ps_q     <= ps_d;
            count_q  <= count_d;
            shadow_q <= shadow_d;
            pwm_q    <= pwm_d;
            tick_q   <= tick_d;
            ramp_q   <= ramp_d;
            run_q    <= run_d;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                target_q[i] <= target_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    assign PWM_output  = pwm_q;
    assign period_tick = tick_q;
    assign ramping     = ramp_q;

endmodule
